// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the multiplexer scan controller: channel count,
// FSM state encoding and the select-to-one-hot decoder.
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_DWELL   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Decode a mux select value into the matching one-hot grant
    // (sel 0 -> 0001, sel 3 -> 1000).
    function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_rr_arbiter4.sv
// Combinational 4-way round-robin search: finds the first set request bit
// starting one position after the last served channel, wrapping around.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       found
);

    // w_rot[k] is the request of channel (last + 1 + k) mod 4, so bit 0 of
    // the rotated vector always holds the highest-priority candidate.
    logic [3:0] w_rot;
    logic [1:0] w_off;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot[gi] = req[last + 2'(gi + 1)];
        end
    endgenerate

    // Lowest set bit of the rotated vector gives the offset from last+1.
    always_comb begin
        w_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 2'(i);
            end
        end
    end

    assign found = |w_rot;
    assign idx   = last + 2'd1 + w_off;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a shared 4:1 mux: picks a requesting channel
// round-robin, drives the select, waits a programmable settle time and
// then captures the mux output into that channel's sample bit.
module mux_scan_ctrl #(
    parameter int NUM_CH  = mux_scan_ctrl_pkg::NUM_CH,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_CH-1:0]  req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_data,
    output logic [1:0]         sel,
    output logic [NUM_CH-1:0]  grant,
    output logic [NUM_CH-1:0]  sample,
    output logic               sample_valid,
    output logic [1:0]         sample_ch,
    output logic               busy
);

    import mux_scan_ctrl_pkg::*;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [1:0]         r_last;
    logic [NUM_CH-1:0]  r_grant;
    logic [NUM_CH-1:0]  r_sample;
    logic               r_sample_valid;
    logic [1:0]         r_sample_ch;
    logic               r_busy;
    logic [DWELL_W-1:0] r_cnt;

    logic [1:0]         w_arb_idx;
    logic               w_arb_found;

    rr_arbiter4 u_arb (
        .req   (req),
        .last  (r_last),
        .idx   (w_arb_idx),
        .found (w_arb_found)
    );

    // Controller FSM; every output is a register updated on the transition
    // into the state where it must be visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sel          <= 2'd0;
            r_last         <= 2'd3;  // channel 0 wins the first search
            r_grant        <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_sample_ch    <= 2'd0;
            r_busy         <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_grant <= '0;
                    if (en && (|req)) begin
                        r_state <= ST_ARB;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    // Request and dwell are latched here; later changes do
                    // not affect the transaction in flight.
                    if (w_arb_found) begin
                        r_sel   <= w_arb_idx;
                        r_grant <= sel_to_onehot(w_arb_idx);
                        r_cnt   <= dwell;
                        r_state <= ST_DWELL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DWELL: begin
                    if (r_cnt == '0) begin
                        r_sample[r_sel] <= mux_data;
                        r_grant         <= '0;
                        r_sample_valid  <= 1'b1;
                        r_sample_ch     <= r_sel;
                        r_last          <= r_sel;
                        r_state         <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (en && (|req)) begin
                        r_state <= ST_ARB;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel          = r_sel;
    assign grant        = r_grant;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed and randomized bench for the mux scan controller. Cycle numbers
// in the tasks count from the edge at which the controller first sees the
// request while idle (that edge is edge 0, cycle 1 follows it).
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [7:0] dwell;
    logic       mux_data;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [3:0] sample;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux_scan_ctrl #(.NUM_CH(4), .DWELL_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .dwell        (dwell),
        .mux_data     (mux_data),
        .sel          (sel),
        .grant        (grant),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; req = 4'b0; dwell = 8'd0; mux_data = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; req = 4'b1111; dwell = 8'd0; mux_data = 1'b1;
        tick();
        tick();
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
        checks++; if (sample !== 4'b0) begin errors++; $display("FAIL reset_sample got %b exp 0000", sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        checks++; if (sample_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", sample_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        $display("test_reset done");
    endtask

    // Single channel 2, dwell 3: grant in cycles 2-5, capture in 6, repeat in 12.
    task automatic test_single();
        do_reset();
        req = 4'b0100; dwell = 8'd3; mux_data = 1'b1; en = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_arb_busy got %b exp 1", busy); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_arb_grant got %b exp 0000", grant); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant c%0d got %b exp 0100", c, grant); end
            checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel c%0d got %0d exp 2", c, sel); end
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL single_novalid c%0d got %b exp 0", c, sample_valid); end
        end
        tick();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", sample_valid); end
        checks++; if (sample_ch !== 2'd2) begin errors++; $display("FAIL single_ch got %0d exp 2", sample_ch); end
        checks++; if (sample !== 4'b0100) begin errors++; $display("FAIL single_sample got %b exp 0100", sample); end
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_cap_grant got %b exp 0000", grant); end
        $display("capture ch=2 data=1 cycle=6");
        for (int c = 7; c <= 11; c++) begin
            tick();
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL repeat_novalid c%0d got %b exp 0", c, sample_valid); end
        end
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_ch !== 2'd2) begin
            errors++; $display("FAIL repeat_valid got v=%b ch=%0d exp v=1 ch=2", sample_valid, sample_ch);
        end
        $display("capture ch=2 data=1 cycle=12");
        en = 1'b0; req = 4'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
        $display("test_single done");
    endtask

    // All requests, dwell 0: channels rotate 0,1,2,3,0 with a 3-cycle period.
    task automatic test_rotate();
        logic [3:0] exp_sample;
        logic [4:0] md_pat;
        logic [1:0] exp_ch;
        md_pat = 5'b01101;  // mux_data for capture k is md_pat[k]
        exp_sample = 4'b0;
        do_reset();
        req = 4'b1111; dwell = 8'd0; en = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_ch = 2'(k);
            tick();
            checks++; if (grant !== (4'b0001 << exp_ch)) begin errors++; $display("FAIL rot_grant k%0d got %b exp ch %0d", k, grant, exp_ch); end
            mux_data = md_pat[k];
            exp_sample[exp_ch] = md_pat[k];
            tick();
            checks++; if (sample_valid !== 1'b1 || sample_ch !== exp_ch) begin
                errors++; $display("FAIL rot_capture k%0d got v=%b ch=%0d exp v=1 ch=%0d", k, sample_valid, sample_ch, exp_ch);
            end
            checks++; if (sample !== exp_sample) begin errors++; $display("FAIL rot_sample k%0d got %b exp %b", k, sample, exp_sample); end
            $display("capture ch=%0d data=%0b", exp_ch, md_pat[k]);
            if (k == 4) begin
                en = 1'b0; req = 4'b0;
            end
            tick();
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rot_gap k%0d got %b exp 0", k, sample_valid); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rot_idle_busy got %b exp 0", busy); end
        $display("test_rotate done");
    endtask

    // Request and dwell dropped mid-dwell: capture still lands in cycle 8.
    task automatic test_drop();
        do_reset();
        req = 4'b0010; dwell = 8'd5; en = 1'b1; mux_data = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b exp 0010", grant); end
        req = 4'b0; dwell = 8'd0;
        for (int c = 3; c <= 7; c++) begin
            tick();
            checks++; if (grant !== 4'b0010 || sample_valid !== 1'b0) begin
                errors++; $display("FAIL drop_hold c%0d got grant=%b v=%b exp grant=0010 v=0", c, grant, sample_valid);
            end
        end
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_ch !== 2'd1 || sample !== 4'b0010) begin
            errors++; $display("FAIL drop_capture got v=%b ch=%0d s=%b exp v=1 ch=1 s=0010", sample_valid, sample_ch, sample);
        end
        $display("capture ch=1 data=1 cycle=8");
        tick();
        checks++; if (busy !== 1'b0 || grant !== 4'b0) begin errors++; $display("FAIL drop_idle got busy=%b grant=%b exp 0 0000", busy, grant); end
        $display("test_drop done");
    endtask

    // en dropped in cycle 3: capture of channel 0 in cycle 5, then nothing more.
    task automatic test_en_drop();
        int extra;
        extra = 0;
        do_reset();
        req = 4'b1111; dwell = 8'd2; en = 1'b1; mux_data = 1'b0;
        tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_ch !== 2'd0) begin
            errors++; $display("FAIL endrop_capture got v=%b ch=%0d exp v=1 ch=0", sample_valid, sample_ch);
        end
        $display("capture ch=0 data=0 cycle=5");
        for (int c = 6; c <= 15; c++) begin
            tick();
            if (grant !== 4'b0 || sample_valid !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL endrop_quiet got %0d active cycles exp 0", extra); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got %b exp 0", busy); end
        $display("test_en_drop done");
    endtask

    // Reset in the third dwell cycle discards the transaction; priority restarts at 0.
    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001; dwell = 8'd0; en = 1'b1; mux_data = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (sample_valid !== 1'b1 || sample !== 4'b0001) begin
            errors++; $display("FAIL rmid_first got v=%b s=%b exp v=1 s=0001", sample_valid, sample);
        end
        req = 4'b1111; dwell = 8'd4;
        tick();
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_grant got %b exp 0010", grant); end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (sel !== 2'd0 || grant !== 4'b0 || sample !== 4'b0 || sample_valid !== 1'b0 || sample_ch !== 2'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_zero got sel=%0d g=%b s=%b v=%b ch=%0d b=%b exp all 0", sel, grant, sample, sample_valid, sample_ch, busy);
        end
        rst_n = 1'b1; dwell = 8'd0;
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rmid_novalid got %b exp 0", sample_valid); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_regrant got %b exp 0001", grant); end
        $display("test_reset_mid done");
    endtask

    // Random stream: structural grant checks and capture data against the
    // mux_data value presented at the final dwell edge.
    task automatic test_random();
        logic       last_md;
        logic [3:0] prev_grant;
        int         captures;
        captures   = 0;
        prev_grant = 4'b0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req      = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 7) != 0);
            dwell    = 8'($urandom_range(0, 3));
            mux_data = 1'($urandom_range(0, 1));
            last_md  = mux_data;
            tick();
            checks++; if (!$onehot0(grant)) begin errors++; $display("FAIL rnd_onehot n%0d got %b exp one-hot or zero", n, grant); end
            if (grant != 4'b0) begin
                checks++; if (grant !== (4'b0001 << sel)) begin errors++; $display("FAIL rnd_selgrant n%0d got g=%b sel=%0d", n, grant, sel); end
            end
            if (sample_valid === 1'b1) begin
                captures++;
                checks++; if (sample[sample_ch] !== last_md) begin
                    errors++; $display("FAIL rnd_data n%0d ch=%0d got %b exp %b", n, sample_ch, sample[sample_ch], last_md);
                end
                checks++; if (prev_grant !== (4'b0001 << sample_ch) || sel !== sample_ch) begin
                    errors++; $display("FAIL rnd_chan n%0d got prev_grant=%b sel=%0d ch=%0d", n, prev_grant, sel, sample_ch);
                end
                $display("capture ch=%0d data=%0b", sample_ch, last_md);
            end
            prev_grant = grant;
        end
        checks++; if (captures == 0) begin errors++; $display("FAIL rnd_activity got 0 captures exp >0"); end
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 4'b0; dwell = 8'd0; mux_data = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_drop();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
